// File: rtl/reg_bist_master.sv
// rtl/reg_bist_master.sv - register-bus BIST master: write/read-check/march sequences over a register window.
// Optional watchdog abort enabled by defining REG_BIST_TIMEOUT_EN.
module reg_bist_master #(
    parameter int unsigned   AW            = 32,
    parameter int unsigned   DW            = 32,
    parameter int unsigned   NumRegs       = 8,
    parameter logic [AW-1:0] BaseAddr      = '0,
    parameter int unsigned   Stride        = DW / 8,
    parameter int unsigned   ErrCntW       = 8,
    parameter int unsigned   TimeoutCycles = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic [1:0]         mode_i,
    input  logic [DW-1:0]      seed_i,
    output logic [AW-1:0]      reg_addr_o,
    output logic               reg_write_o,
    output logic [DW-1:0]      reg_wdata_o,
    output logic [DW/8-1:0]    reg_wstrb_o,
    output logic               reg_valid_o,
    input  logic [DW-1:0]      reg_rdata_i,
    input  logic               reg_error_i,
    input  logic               reg_ready_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               pass_o,
    output logic [ErrCntW-1:0] err_cnt_o,
    output logic [AW-1:0]      first_err_addr_o,
    output logic               timeout_o
);
    localparam int unsigned IdxW = (NumRegs > 1) ? $clog2(NumRegs) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} state_e;

    state_e              state_q, state_d;
    logic [1:0]          mode_q, mode_d;
    logic [DW-1:0]       seed_q, seed_d;
    logic [1:0]          pass_idx_q, pass_idx_d;
    logic [IdxW-1:0]     idx_q, idx_d;
    logic [ErrCntW-1:0]  err_cnt_q, err_cnt_d;
    logic [AW-1:0]       first_err_q, first_err_d;
    logic                pass_q, pass_d;
    logic                timeout_q, timeout_d;

    logic [1:0]          phase;
    logic [1:0]          last_pass_idx;
    logic [DW-1:0]       pattern;
    logic [DW-1:0]       exp_data;
    logic [AW-1:0]       addr;
    logic                valid;
    logic                is_read;
    logic                hs;
    logic                txn_err;
    logic                timeout_hit;

    // Phase bit 0 selects read, bit 1 selects the inverted pattern (W0,R0,W1,R1).
    assign phase    = (mode_q == 2'd1) ? 2'd1 : pass_idx_q;
    assign is_read  = phase[0];
    assign pattern  = seed_q + DW'(idx_q);
    assign exp_data = phase[1] ? ~pattern : pattern;
    assign addr     = BaseAddr + AW'(idx_q) * AW'(Stride);
    assign valid    = (state_q == S_RUN);
    assign hs       = valid && reg_ready_i;
    assign txn_err  = hs && (reg_error_i || (is_read && (reg_rdata_i != exp_data)));

    always_comb begin
        last_pass_idx = 2'd0;
        case (mode_q)
            2'd2:    last_pass_idx = 2'd1;
            2'd3:    last_pass_idx = 2'd3;
            default: last_pass_idx = 2'd0;
        endcase
    end

`ifdef REG_BIST_TIMEOUT_EN
    localparam int unsigned WaitW = $clog2(TimeoutCycles + 1);
    logic [WaitW-1:0] wait_q, wait_d;

    assign timeout_hit = valid && !reg_ready_i && (wait_q == WaitW'(TimeoutCycles - 1));

    always_comb begin
        wait_d = wait_q;
        if (state_q == S_IDLE) begin
            wait_d = '0;
        end else if (hs) begin
            wait_d = '0;
        end else if (valid) begin
            wait_d = wait_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        seed_d      = seed_q;
        pass_idx_d  = pass_idx_q;
        idx_d       = idx_q;
        err_cnt_d   = err_cnt_q;
        first_err_d = first_err_q;
        pass_d      = pass_q;
        timeout_d   = timeout_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    mode_d      = mode_i;
                    seed_d      = seed_i;
                    err_cnt_d   = '0;
                    first_err_d = '0;
                    pass_d      = 1'b0;
                    timeout_d   = 1'b0;
                    idx_d       = '0;
                    pass_idx_d  = '0;
                    state_d     = S_RUN;
                end
            end
            S_RUN: begin
                // A timed-out request counts as one error at the stalled address.
                if (txn_err || timeout_hit) begin
                    if (err_cnt_q != '1) begin
                        err_cnt_d = err_cnt_q + 1'b1;
                    end
                    if (err_cnt_q == '0) begin
                        first_err_d = addr;
                    end
                end
                if (timeout_hit) begin
                    timeout_d = 1'b1;
                    pass_d    = 1'b0;
                    state_d   = S_FINISH;
                end else if (hs) begin
                    if (idx_q == IdxW'(NumRegs - 1)) begin
                        idx_d = '0;
                        if (pass_idx_q == last_pass_idx) begin
                            pass_d  = (err_cnt_d == '0);
                            state_d = S_FINISH;
                        end else begin
                            pass_idx_d = pass_idx_q + 1'b1;
                        end
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q     <= S_IDLE;
            mode_q      <= '0;
            seed_q      <= '0;
            pass_idx_q  <= '0;
            idx_q       <= '0;
            err_cnt_q   <= '0;
            first_err_q <= '0;
            pass_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            seed_q      <= seed_d;
            pass_idx_q  <= pass_idx_d;
            idx_q       <= idx_d;
            err_cnt_q   <= err_cnt_d;
            first_err_q <= first_err_d;
            pass_q      <= pass_d;
            timeout_q   <= timeout_d;
        end
    end

    assign reg_valid_o      = valid;
    assign reg_write_o      = valid && !is_read;
    assign reg_addr_o       = valid ? addr : '0;
    assign reg_wdata_o      = (valid && !is_read) ? exp_data : '0;
    assign reg_wstrb_o      = '1;
    assign busy_o           = valid;
    assign done_o           = (state_q == S_FINISH);
    assign pass_o           = pass_q;
    assign err_cnt_o        = err_cnt_q;
    assign first_err_addr_o = first_err_q;
    assign timeout_o        = timeout_q;
endmodule

// File: tb/tb_reg_bist_master.sv
// tb/tb_reg_bist_master.sv - table-driven bench for reg_bist_master against a small register-memory slave.
module tb_reg_bist_master;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NR = 4;
    localparam int ECW = 3;
    localparam int TO = 16;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start_i;
    logic [1:0]     mode_i;
    logic [DW-1:0]  seed_i;
    logic [AW-1:0]  reg_addr;
    logic           reg_write;
    logic [DW-1:0]  reg_wdata;
    logic [DW/8-1:0] reg_wstrb;
    logic           reg_valid;
    logic [DW-1:0]  reg_rdata;
    logic           reg_error;
    logic           reg_ready;
    logic           busy_o;
    logic           done_o;
    logic           pass_o;
    logic [ECW-1:0] err_cnt_o;
    logic [AW-1:0]  first_err_addr_o;
    logic           timeout_o;

    always #5 clk = ~clk;

    reg_bist_master #(
        .AW(AW), .DW(DW), .NumRegs(NR), .BaseAddr(32'h0), .Stride(4),
        .ErrCntW(ECW), .TimeoutCycles(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .mode_i(mode_i), .seed_i(seed_i),
        .reg_addr_o(reg_addr), .reg_write_o(reg_write), .reg_wdata_o(reg_wdata),
        .reg_wstrb_o(reg_wstrb), .reg_valid_o(reg_valid), .reg_rdata_i(reg_rdata),
        .reg_error_i(reg_error), .reg_ready_i(reg_ready), .busy_o(busy_o), .done_o(done_o),
        .pass_o(pass_o), .err_cnt_o(err_cnt_o), .first_err_addr_o(first_err_addr_o),
        .timeout_o(timeout_o)
    );

    // Slave: 16-word memory, optional random stalls, error injection and a stuck-at-0 bit 0 at 0x8.
    logic [31:0] mem [0:15];
    int          stall_left;
    int          txn_cnt;
    int          err_txn;
    int unsigned max_stall;
    bit          err_all, never_ready, stuck_en, clear_mem;

    assign reg_ready = reg_valid && !never_ready && (stall_left == 0);
    assign reg_rdata = reg_ready ? mem[reg_addr[5:2]] : 32'h0;
    assign reg_error = reg_ready && (err_all || (txn_cnt == err_txn));

    always @(posedge clk) begin
        if (clear_mem) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
        end
        if (start_i && !busy_o) begin
            txn_cnt    <= 0;
            stall_left <= int'($urandom_range(0, max_stall));
        end else if (reg_valid && reg_ready) begin
            if (reg_write)
                mem[reg_addr[5:2]] <= (stuck_en && reg_addr == 32'h8) ? (reg_wdata & ~32'h1) : reg_wdata;
            txn_cnt    <= txn_cnt + 1;
            stall_left <= int'($urandom_range(0, max_stall));
        end else if (reg_valid && stall_left > 0) begin
            stall_left <= stall_left - 1;
        end
    end

    logic        prev_stall = 1'b0;
    logic [31:0] p_addr, p_wdata;
    logic        p_write;
    int          stab_err = 0;
    int          stall_seen = 0;

    always @(negedge clk) begin
        if (prev_stall && !(reg_valid && reg_addr == p_addr && reg_wdata == p_wdata && reg_write == p_write))
            stab_err++;
        prev_stall = reg_valid && !reg_ready && !never_ready && !rst_n;
        if (prev_stall) stall_seen++;
        p_addr  = reg_addr;
        p_wdata = reg_wdata;
        p_write = reg_write;
    end

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_seq(input logic [1:0] m, input logic [31:0] s, output int cyc);
        @(negedge clk);
        mode_i  = m;
        seed_i  = s;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        mode_i  = ~m;
        seed_i  = ~s;
        cyc = 1;
        while (!done_o && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        if (!done_o) cyc = -1;
    endtask

    typedef struct {
        logic [1:0]  mode;
        logic [31:0] seed;
        bit          zero_mem;
        bit          stuck;
        bit          err_all;
        int          err_txn;
        int unsigned max_stall;
        int          exp_cyc;
        bit          exp_pass;
        logic [31:0] exp_err;
        logic [31:0] exp_first;
    } vec_t;

    vec_t vecs [8];
    int   cyc;
    int   done_cnt;

    initial begin
        rst_n = 1'b1; start_i = 1'b0; mode_i = 2'd0; seed_i = '0;
        err_all = 1'b0; never_ready = 1'b0; stuck_en = 1'b0; clear_mem = 1'b1;
        max_stall = 0; err_txn = -1;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy_o), 32'h0);
        check("rst_done", 32'(done_o), 32'h0);
        check("rst_pass", 32'(pass_o), 32'h0);
        check("rst_err_cnt", 32'(err_cnt_o), 32'h0);
        check("rst_first_err", first_err_addr_o, 32'h0);
        check("rst_valid", 32'(reg_valid), 32'h0);
        check("rst_write", 32'(reg_write), 32'h0);
        check("rst_timeout", 32'(timeout_o), 32'h0);
        rst_n = 1'b0;
        clear_mem = 1'b0;

        //          mode   seed          zero stuck eall etxn stall cyc pass err first
        vecs[0] = '{2'd2, 32'hdeadbeef, 0, 0, 0, -1, 0,  9, 1, 32'd0, 32'h0};
        vecs[1] = '{2'd0, 32'h00000010, 0, 0, 0, -1, 0,  5, 1, 32'd0, 32'h0};
        vecs[2] = '{2'd1, 32'h00000010, 0, 0, 0, -1, 0,  5, 1, 32'd0, 32'h0};
        vecs[3] = '{2'd3, 32'h00000000, 0, 1, 0, -1, 0, 17, 0, 32'd1, 32'h8};
        vecs[4] = '{2'd1, 32'h00000000, 1, 0, 0, -1, 0,  5, 0, 32'd3, 32'h4};
        vecs[5] = '{2'd3, 32'h00000055, 0, 0, 1, -1, 0, 17, 0, 32'd7, 32'h0};
        vecs[6] = '{2'd2, 32'hffffffff, 0, 0, 0, -1, 0,  9, 1, 32'd0, 32'h0};
        vecs[7] = '{2'd2, 32'h00001234, 0, 0, 0,  2, 5, -1, 0, 32'd1, 32'h8};

        for (int v = 0; v < 8; v++) begin
            if (vecs[v].zero_mem) begin
                @(negedge clk); clear_mem = 1'b1;
                @(negedge clk); clear_mem = 1'b0;
            end
            stuck_en  = vecs[v].stuck;
            err_all   = vecs[v].err_all;
            err_txn   = vecs[v].err_txn;
            max_stall = vecs[v].max_stall;
            run_seq(vecs[v].mode, vecs[v].seed, cyc);
            check($sformatf("v%0d_done_seen", v), 32'(cyc > 0), 32'h1);
            if (vecs[v].exp_cyc >= 0) check($sformatf("v%0d_done_cycle", v), cyc, vecs[v].exp_cyc);
            check($sformatf("v%0d_busy_at_done", v), 32'(busy_o), 32'h0);
            check($sformatf("v%0d_pass", v), 32'(pass_o), 32'(vecs[v].exp_pass));
            check($sformatf("v%0d_err_cnt", v), 32'(err_cnt_o), vecs[v].exp_err);
            check($sformatf("v%0d_first_err", v), first_err_addr_o, vecs[v].exp_first);
            if (v == 0) begin
                for (int i = 0; i < NR; i++)
                    check($sformatf("v0_mem%0d", i), mem[i], 32'hdeadbeef + i);
            end
        end
        stuck_en = 1'b0; err_all = 1'b0; err_txn = -1; max_stall = 0;

        // start_i and mode changes mid-run must not disturb a WRITE_READ sequence.
        @(negedge clk);
        mode_i = 2'd2; seed_i = 32'h100; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        cyc = 1; done_cnt = 0;
        while (cyc < 14) begin
            if (cyc == 3) begin start_i = 1'b1; mode_i = 2'd3; end
            if (cyc == 4) start_i = 1'b0;
            if (done_o) begin
                done_cnt++;
                check("midstart_done_cycle", cyc, 9);
            end
            @(negedge clk);
            cyc++;
        end
        check("midstart_done_count", done_cnt, 1);
        check("midstart_idle_after", 32'(busy_o), 32'h0);
        check("midstart_pass", 32'(pass_o), 32'h1);

        // Asynchronous reset mid-run.
        @(negedge clk);
        mode_i = 2'd3; seed_i = 32'h0; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_reset_busy", 32'(busy_o), 32'h1);
        #2 rst_n = 1'b1;
        #1;
        check("async_rst_valid", 32'(reg_valid), 32'h0);
        check("async_rst_busy", 32'(busy_o), 32'h0);
        @(negedge clk);
        rst_n = 1'b0;
        run_seq(2'd0, 32'h77, cyc);
        check("post_reset_done_cycle", cyc, 5);

`ifdef REG_BIST_TIMEOUT_EN
        never_ready = 1'b1;
        run_seq(2'd0, 32'h0, cyc);
        check("to_done_seen", 32'(cyc > 0), 32'h1);
        check("to_timeout", 32'(timeout_o), 32'h1);
        check("to_pass", 32'(pass_o), 32'h0);
        check("to_err_cnt", 32'(err_cnt_o), 32'h1);
        check("to_first_err", first_err_addr_o, 32'h0);
        check("to_valid_dropped", 32'(reg_valid), 32'h0);
        never_ready = 1'b0;
`else
        check("timeout_tied_low", 32'(timeout_o), 32'h0);
`endif

        check("stall_fields_stable", stab_err, 0);
        check("stalls_exercised", 32'(stall_seen > 0), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/reg_bist_master.md
# reg_bist_master

Parametrised register-bus built-in self-test master. Generates write, read-check, write-then-read and march sequences over a configurable window of registers. Compares read data against a seeded pattern, counts errors and reports pass/fail. Sits in front of any register-interface slave (e.g. generated `*_reg_top` blocks) for bring-up and regression, replacing hand-written single-address write/readback stimulus.

## Interface
- `AW`, 32, address width
- `DW`, 32, data width; multiple of 8
- `NumRegs`, 8, registers in the test window; ≥1
- `BaseAddr`, 0, address of first register
- `Stride`, `DW/8`, address increment between registers
- `ErrCntW`, 8, error counter width
- `TimeoutCycles`, 64, watchdog limit; used only with the macro
- `clk` in 1 clock
- `rst_n` in 1 reset, asynchronous, active-high
- `start_i` in 1 start pulse, sampled only in IDLE
- `mode_i` in 2 0=WRITE_ONLY, 1=READ_CHECK, 2=WRITE_READ, 3=MARCH; latched at start
- `seed_i` in DW pattern seed; latched at start
- `reg_addr_o` out AW request address
- `reg_write_o` out 1 1=write, 0=read
- `reg_wdata_o` out DW write data
- `reg_wstrb_o` out DW/8 byte strobes; always all-ones
- `reg_valid_o` out 1 request valid
- `reg_rdata_i` in DW read data, valid with ready
- `reg_error_i` in 1 slave error, valid with ready
- `reg_ready_i` in 1 transaction complete
- `busy_o` out 1 sequence running
- `done_o` out 1 one-cycle completion pulse
- `pass_o` out 1 last sequence error-free; held until next start
- `err_cnt_o` out ErrCntW errors of last/current sequence, saturating
- `first_err_addr_o` out AW address of first error; 0 if none
- `timeout_o` out 1 sequence aborted by watchdog (macro only, else tied 0)

## Operation
- States: IDLE, RUN, FINISH. Pass sub-sequence: W0, R0, W1, R1.
- Pass list per mode: WRITE_ONLY={W0}; READ_CHECK={R0}; WRITE_READ={W0,R0}; MARCH={W0,R0,W1,R1}.
- Pattern: P0(i) = seed + i (mod 2^DW), i = register index 0..NumRegs-1. P1(i) = ~P0(i).
- Address(i) = BaseAddr + i*Stride, truncated to AW bits (wraps silently).
- IDLE: start_i=1 latches mode/seed, clears err_cnt_o, first_err_addr_o, pass_o, timeout_o; goes to RUN at index 0 of first pass.
- RUN: drive one request per index, ascending. Write passes: wdata = P0/P1. Read passes: compare rdata with expected pattern of same polarity.
- Error counted when ready=1 and (reg_error_i=1, or read pass and rdata ≠ expected). At most one error per transaction.
- err_cnt_o saturates at 2^ErrCntW-1. first_err_addr_o captured on first error only.
- After last index of last pass → FINISH: done_o=1 for one cycle, pass_o = (err_cnt==0 && !timeout), back to IDLE.
- start_i while busy ignored. mode_i/seed_i changes mid-sequence have no effect.

## Timing
- Reset: all outputs 0, FSM IDLE, counters 0; takes effect immediately regardless of clock, aborting any transaction (valid drops).
- Cycle 0: start sampled. Cycle 1: busy_o=1, first reg_valid_o=1.
- Request fields stable while valid=1 and ready=0. Handshake completes in the cycle ready=1 with valid=1.
- Next request driven in the cycle after a handshake with valid kept high (no bubble). ready=1 permanently ⇒ one transaction per cycle.
- Total: with ready tied high, K passes, done_o asserted in cycle K*NumRegs+1; busy_o deasserts the same cycle.
- ready_i ignored when valid_o=0.

## Configuration
- `REG_BIST_TIMEOUT_EN` defined: a wait counter resets on each handshake and increments each cycle valid=1 and ready=0. Reaching TimeoutCycles: drop valid, set timeout_o=1, count one error at current address, go to FINISH (done_o pulse, pass_o=0). timeout_o held until next start.
- Undefined: no counter, master waits indefinitely, timeout_o constant 0.

## Test plan
- WRITE_READ, NumRegs=4, seed=0xdeadbeef, ideal memory, ready=1 → writes 0xdeadbeef..0xdeadbef2 at 0x0,0x4,0x8,0xc; done_o in cycle 9; pass_o=1, err_cnt_o=0.
- MARCH, seed=0, memory bit 0 stuck-at-0 at address 0x8 → R0 passes (P0(2)=2), R1 fails (expect 0xfffffffd); err_cnt_o=1, first_err_addr_o=0x8, pass_o=0.
- READ_CHECK on memory zero-filled, seed=0, NumRegs=4 → indices 1..3 mismatch; err_cnt_o=3, first_err_addr_o=0x4.
- Random ready stalls 0-5 cycles, reg_error_i=1 on third transaction → request fields stable during stalls, err_cnt_o=1; start_i pulsed mid-run ignored.
- ErrCntW=2, all reads erroring, NumRegs=8 → err_cnt_o saturates at 3; rst_n asserted mid-run → valid_o, busy_o drop immediately.
- With `REG_BIST_TIMEOUT_EN`, TimeoutCycles=16, ready never asserted → timeout_o=1, done_o pulse, pass_o=0, err_cnt_o=1, first_err_addr_o=BaseAddr.
